diff_arbiter: RTL and testbench
===============================

Name: diff_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one internal diff_24bit subtractor among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block accepts one request at a time, registers the operands, computes a - b, and returns the result tagged with the requester index over a valid/ready response channel.
- Sits between multiple client datapaths and the single shared subtractor.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 24, operand/result width; fixed to 24 to match diff_24bit.
- ID_W, $clog2(NUM_REQ), width of resp_id.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  flattened minuends; requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  flattened subtrahends, same packing.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- resp_diff  output  WIDTH  a - b result.
- resp_borrow  output  1  1 when a < b (unsigned).
- resp_id  output  ID_W  index of the requester that owns the result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; resp_valid=0, resp_diff=0, resp_borrow=0, resp_id=0.
  - req_ready=0; operand regs=0; priority pointer ptr=NUM_REQ-1, so index 0 wins first.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - req_ready is a combinational one-hot for the first i with req_valid[i]=1, searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - No valid -> req_ready=0, stay IDLE.
  - On accept (req_valid[i] & req_ready[i]): latch req_a/req_b slice i into op_a/op_b, latch gnt_id=i, set ptr=i, go to CALC.
  - req_ready is never asserted outside IDLE.
- CALC:
  - op_a/op_b drive the diff_24bit instance.
  - Register resp_diff=diff, resp_borrow=(op_a<op_b), resp_id=gnt_id; set resp_valid=1; go to RESP.
- RESP:
  - resp_valid=1; resp_diff, resp_borrow and resp_id held stable until resp_ready=1.
  - On resp_valid & resp_ready: resp_valid=0 next cycle, go to IDLE.
- Latency and throughput:
  - Accept at cycle T -> resp_valid=1 at T+2.
  - One result per 3 cycles minimum with resp_ready tied high.
- Arithmetic:
  - diff = (op_a - op_b) mod 2^24.
  - resp_borrow is the unsigned borrow out.
  - Equal operands -> 0, borrow 0.
- Fairness:
  - A requester holding valid is granted within NUM_REQ accepts.
  - Requesters must hold req_valid and operands stable until accepted; dropping valid before accept is allowed and simply skips that requester.
- Simultaneous events:
  - req_valid changes while in CALC/RESP are ignored until IDLE.
  - A new request arriving in the same cycle the response handshake completes is accepted in the following IDLE cycle, not the same cycle.
- Reset mid-operation: any in-flight CALC/RESP result is discarded and no response is issued.

Optional Feature:
- Macro: DIFF_ARB_SAT_EN.
- Defined:
  - In CALC, if op_a < op_b then resp_diff=0 (saturating subtract).
  - resp_borrow still reports 1.
- Undefined: resp_diff is the wrapped modulo-2^24 result.
- Handshake and timing are identical in both builds.

Test Plan:
- Single request, req 0, a=24'h000003, b=24'h000001 -> req_ready[0] pulses 1 cycle; 2 cycles later resp_valid=1, resp_diff=000002, resp_borrow=0, resp_id=0.
- req 2, a=24'hFFFFFF, b=24'h000001 -> resp_diff=FFFFFE, borrow 0, id 2; then a=b=24'h123456 -> resp_diff=000000, borrow 0.
- Underflow, a=24'h000001, b=24'h000002:
  - macro undefined -> resp_diff=FFFFFF, borrow 1.
  - DIFF_ARB_SAT_EN -> resp_diff=000000, borrow 1.
- All 4 req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0 (resp_id sequence); each requester is accepted once per 4 grants.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_diff and resp_id stable; req_ready stays 0 throughout; resp_ready=1 -> IDLE next cycle.
- rst_n driven 0 during RESP -> resp_valid=0 immediately (async), ptr reset; after release, a request from req 1 alone is granted and produces a correct result.

Source files
------------

// File: rtl/diff_arbiter.sv
// diff_arbiter: round-robin sequencer in front of one shared 24-bit subtractor.
// Define DIFF_ARB_SAT_EN to clamp underflowing results to zero (borrow still reported).

module diff_24bit (
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [23:0] diff,
    output logic        borrow
);
    always_comb begin
        {borrow, diff} = {1'b0, a} - {1'b0, b};
    end
endmodule

module diff_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 24,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_diff,
    output logic                     resp_borrow,
    output logic [ID_W-1:0]          resp_id
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_diff_q, resp_diff_d;
    logic             resp_borrow_q, resp_borrow_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand;
    logic [NUM_REQ-1:0] ready_oh;
    logic [23:0]      sub_diff;
    logic             sub_borrow;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    diff_24bit u_sub (
        .a      (op_a_q),
        .b      (op_b_q),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // Search starts one past the last winner so the previous grantee goes last.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        ready_oh = '0;
        if (rst_n && state_q == IDLE && gnt_found) begin
            ready_oh[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_id_d      = gnt_id_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        resp_valid_d  = resp_valid_q;
        resp_diff_d   = resp_diff_q;
        resp_borrow_d = resp_borrow_q;
        resp_id_d     = resp_id_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    op_a_d   = a_arr[gnt_idx];
                    op_b_d   = b_arr[gnt_idx];
                    gnt_id_d = gnt_idx;
                    ptr_d    = gnt_idx;
                    state_d  = CALC;
                end
            end
            CALC: begin
`ifdef DIFF_ARB_SAT_EN
                resp_diff_d = sub_borrow ? '0 : sub_diff;
`else
                resp_diff_d = sub_diff;
`endif
                resp_borrow_d = sub_borrow;
                resp_id_d     = gnt_id_q;
                resp_valid_d  = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= ID_W'(NUM_REQ - 1);
            gnt_id_q      <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            resp_valid_q  <= 1'b0;
            resp_diff_q   <= '0;
            resp_borrow_q <= 1'b0;
            resp_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_id_q      <= gnt_id_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            resp_valid_q  <= resp_valid_d;
            resp_diff_q   <= resp_diff_d;
            resp_borrow_q <= resp_borrow_d;
            resp_id_q     <= resp_id_d;
        end
    end

    assign req_ready   = ready_oh;
    assign resp_valid  = resp_valid_q;
    assign resp_diff   = resp_diff_q;
    assign resp_borrow = resp_borrow_q;
    assign resp_id     = resp_id_q;
endmodule

// File: tb/tb_diff_arbiter.sv
// Bench for diff_arbiter: directed scenarios with literal results plus randomized
// traffic compared every cycle against a transaction-level model.

module tb_diff_arbiter;
    localparam int N   = 4;
    localparam int W   = 24;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_diff;
    logic           resp_borrow;
    logic [IDW-1:0] resp_id;

    int n_checks = 0;
    int n_pass   = 0;

    diff_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_diff   (resp_diff),
        .resp_borrow (resp_borrow),
        .resp_id     (resp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: a free block grants the round-robin winner; the
    // result shows two cycles after the grant and stays until taken.
    int          m_ptr = N - 1;
    bit          m_busy = 1'b0;
    int          m_lat = 0;
    int          m_id;
    int          m_p;
    logic [23:0] m_a, m_b, m_diff;
    bit          m_borrow;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_resp_diff", 32'(resp_diff), 0);
            chk("rst_resp_borrow", 32'(resp_borrow), 0);
            chk("rst_resp_id", 32'(resp_id), 0);
            m_ptr  = N - 1;
            m_busy = 1'b0;
            m_lat  = 0;
        end else if (!m_busy) begin
            m_p = rr_pick(m_ptr, req_valid);
            chk("model_req_ready", 32'(req_ready), (m_p < 0) ? 32'd0 : (32'd1 << m_p));
            chk("model_idle_resp_valid", 32'(resp_valid), 0);
            if (m_p >= 0) begin
                m_a      = req_a[m_p*W +: W];
                m_b      = req_b[m_p*W +: W];
                m_borrow = (m_a < m_b);
                m_diff   = m_a - m_b;
`ifdef DIFF_ARB_SAT_EN
                if (m_borrow) m_diff = 24'h0;
`endif
                m_id   = m_p;
                m_ptr  = m_p;
                m_busy = 1'b1;
                m_lat  = 1;
            end
        end else begin
            chk("model_busy_req_ready", 32'(req_ready), 0);
            if (m_lat > 0) begin
                chk("model_calc_resp_valid", 32'(resp_valid), 0);
                m_lat--;
            end else begin
                chk("model_resp_valid", 32'(resp_valid), 1);
                chk("model_resp_diff", 32'(resp_diff), 32'(m_diff));
                chk("model_resp_borrow", 32'(resp_borrow), 32'(m_borrow));
                chk("model_resp_id", 32'(resp_id), 32'(m_id));
                if (resp_ready) m_busy = 1'b0;
            end
        end
    end

    task automatic issue(input int idx, input logic [23:0] a, input logic [23:0] b);
        int n;
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[idx] && n < 20);
        chk("grant_seen", 32'(req_ready[idx]), 1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    // Called in the cycle right after the accepting edge.
    task automatic wait_resp(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("ready_one_cycle", 32'(req_ready), 0);
        end while (!resp_valid && n < 20);
        ok = resp_valid;
        chk("resp_latency", 32'(n), 2);
    endtask

    task automatic expect_resp(input string tag, input logic [23:0] d, input bit br, input int id);
        bit ok;
        wait_resp(ok);
        if (ok) begin
            chk({tag, "_diff"}, 32'(resp_diff), 32'(d));
            chk({tag, "_borrow"}, 32'(resp_borrow), 32'(br));
            chk({tag, "_id"}, 32'(resp_id), 32'(id));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    function automatic logic [23:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 24'($urandom_range(0, 3));
            1:       return 24'hFFFFF0 | 24'($urandom_range(0, 15));
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ids [5];
        int          got;
        int          n;
        bit          ok;
        logic [23:0] hold_d;
        logic [IDW-1:0] hold_id;
        logic [N-1:0] acc;

        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready_gated", 32'(req_ready), 0);
        chk("reset_resp_valid", 32'(resp_valid), 0);
        chk("reset_resp_diff", 32'(resp_diff), 0);
        req_valid = '0;
        #2 rst_n = 1'b1;

        issue(0, 24'h000003, 24'h000001);
        expect_resp("basic", 24'h000002, 1'b0, 0);
        issue(2, 24'hFFFFFF, 24'h000001);
        expect_resp("max_a", 24'hFFFFFE, 1'b0, 2);
        issue(2, 24'h123456, 24'h123456);
        expect_resp("equal", 24'h000000, 1'b0, 2);
        issue(1, 24'h000001, 24'h000002);
`ifdef DIFF_ARB_SAT_EN
        expect_resp("underflow", 24'h000000, 1'b1, 1);
`else
        expect_resp("underflow", 24'hFFFFFF, 1'b1, 1);
`endif

        // All requesters pending: grants rotate 0,1,2,3,0 after reset.
        pulse_reset();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = rand_op();
            req_b[i*W +: W] = rand_op();
        end
        req_valid = '1;
        got = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                ids[got] = int'(resp_id);
                got++;
            end
        end
        chk("rr_count", 32'(got), 5);
        chk("rr_order0", 32'(ids[0]), 0);
        chk("rr_order1", 32'(ids[1]), 1);
        chk("rr_order2", 32'(ids[2]), 2);
        chk("rr_order3", 32'(ids[3]), 3);
        chk("rr_order4", 32'(ids[4]), 0);

        // Backpressure with everyone still requesting.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        chk("bp_resp_seen", 32'(resp_valid), 1);
        hold_d  = resp_diff;
        hold_id = resp_id;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(resp_valid), 1);
            chk("bp_diff_held", 32'(resp_diff), 32'(hold_d));
            chk("bp_id_held", 32'(resp_id), 32'(hold_id));
            chk("bp_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_still_valid", 32'(resp_valid), 1);
        @(negedge clk);
        chk("bp_released", 32'(resp_valid), 0);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(negedge clk);

        // Reset while a result is held.
        resp_ready = 1'b0;
        issue(2, 24'h000050, 24'h000020);
        wait_resp(ok);
        chk("pre_reset_valid", 32'(resp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(resp_valid), 0);
        chk("async_reset_ready", 32'(req_ready), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b1100;
        @(negedge clk);
        chk("ptr_after_reset", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = '0;
        expect_resp("post_reset_a", 24'h000030, 1'b0, 2);
        issue(1, 24'h100000, 24'h0ABCDE);
        expect_resp("post_reset_b", 24'h054322, 1'b0, 1);

        // Randomized traffic; pending requests hold operands until accepted.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !acc[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                    req_a[i*W +: W] = rand_op();
                    req_b[i*W +: W] = ($urandom_range(0, 5) == 0) ? req_a[i*W +: W] : rand_op();
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
